cr_huf_comp_sym_coalesce: RTL and testbench

Parametrised N-lane short-symbol coalescer for the Huffman compressor symbol-count path. It accepts a beat of up to LANES short symbols with an arbitrary (non-contiguous) valid mask. It merges duplicate symbols into unique-symbol/count pairs and buffers the result in an internal flop FIFO. The symbol-table builder drains the FIFO through a show-ahead read interface. The block also adds a runtime merge bypass mode, sticky overflow/underflow status, and a programmable ready margin.

---
 rtl/cr_huf_comp_sym_coalesce.sv | 159 +++++++++++++++
 tb/tb_cr_huf_comp_sym_coalesce.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_sym_coalesce.sv
// N-lane short-symbol coalescer: merges duplicate symbols of one beat into
// unique-symbol/count slots, stages them one cycle, then buffers them in a show-ahead flop FIFO.
module cr_huf_comp_sym_coalesce #(
   parameter  int LANES      = 4,
   parameter  int SYM_W      = 10,
   parameter  int DEPTH      = 16,
   parameter  int RDY_MARGIN = 4,
   localparam int CNT_W      = $clog2(LANES + 1),
   localparam int USED_W     = $clog2(DEPTH + 1),
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     merge_en,
   input  logic                     in_wr,
   input  logic [LANES-1:0]         in_vld,
   input  logic [LANES*SYM_W-1:0]   in_sym,
   input  logic [3:0]               in_seq_id,
   input  logic [1:0]               in_eob,
   output logic                     in_rdy,
   output logic                     out_vld,
   output logic [LANES*SYM_W-1:0]   out_sym,
   output logic [LANES*CNT_W-1:0]   out_cnt,
   output logic [3:0]               out_seq_id,
   output logic [1:0]               out_eob,
   input  logic                     out_rd,
   output logic [USED_W-1:0]        used_slots,
   output logic                     overflow,
   output logic                     underflow
);

   logic [LANES*SYM_W-1:0] w_pack_sym;
   logic [LANES*CNT_W-1:0] w_pack_cnt;

   // Slots fill in first-occurrence order; a lane either bumps an earlier slot or opens the next one.
   always_comb begin : coalesce
      logic [SYM_W-1:0] slot_sym [LANES];
      logic [CNT_W-1:0] slot_cnt [LANES];
      logic [SYM_W-1:0] lane_sym;
      logic             hit;
      int               n_used;
      n_used   = 0;
      hit      = 1'b0;
      lane_sym = '0;
      for (int k = 0; k < LANES; k++) begin
         slot_sym[k] = '0;
         slot_cnt[k] = '0;
      end
      for (int i = 0; i < LANES; i++) begin
         lane_sym = in_sym[i*SYM_W +: SYM_W];
         hit      = 1'b0;
         if (in_vld[i]) begin
            for (int k = 0; k < LANES; k++) begin
               if (merge_en && !hit && (k < n_used) && (slot_sym[k] == lane_sym)) begin
                  slot_cnt[k] = slot_cnt[k] + CNT_W'(1);
                  hit         = 1'b1;
               end
            end
            if (!hit) begin
               for (int k = 0; k < LANES; k++) begin
                  if (k == n_used) begin
                     slot_sym[k] = lane_sym;
                     slot_cnt[k] = CNT_W'(1);
                  end
               end
               n_used = n_used + 1;
            end
         end
      end
      w_pack_sym = '0;
      w_pack_cnt = '0;
      for (int k = 0; k < LANES; k++) begin
         w_pack_sym[k*SYM_W +: SYM_W] = slot_sym[k];
         w_pack_cnt[k*CNT_W +: CNT_W] = slot_cnt[k];
      end
   end

   logic                   r_stg_vld;
   logic [LANES*SYM_W-1:0] r_stg_sym;
   logic [LANES*CNT_W-1:0] r_stg_cnt;
   logic [3:0]             r_stg_seq;
   logic [1:0]             r_stg_eob;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg_vld <= 1'b0;
         r_stg_sym <= '0;
         r_stg_cnt <= '0;
         r_stg_seq <= '0;
         r_stg_eob <= '0;
      end else begin
         r_stg_vld <= in_wr;
         if (in_wr) begin
            r_stg_sym <= w_pack_sym;
            r_stg_cnt <= w_pack_cnt;
            r_stg_seq <= in_seq_id;
            r_stg_eob <= in_eob;
         end
      end
   end

   logic [LANES*SYM_W-1:0] r_mem_sym [DEPTH];
   logic [LANES*CNT_W-1:0] r_mem_cnt [DEPTH];
   logic [3:0]             r_mem_seq [DEPTH];
   logic [1:0]             r_mem_eob [DEPTH];
   logic [ADDR_W-1:0]      r_wptr;
   logic [ADDR_W-1:0]      r_rptr;
   logic [USED_W-1:0]      r_used;
   logic                   r_ovf;
   logic                   r_udf;

   logic w_not_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_not_empty = (r_used != '0);
   assign w_full      = (r_used == USED_W'(DEPTH));
   assign w_pop       = out_rd && w_not_empty;
   // When full, the slot being popped this cycle is the one the push overwrites.
   assign w_push      = r_stg_vld && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_sym[r_wptr] <= r_stg_sym;
         r_mem_cnt[r_wptr] <= r_stg_cnt;
         r_mem_seq[r_wptr] <= r_stg_seq;
         r_mem_eob[r_wptr] <= r_stg_eob;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_used <= '0;
         r_ovf  <= 1'b0;
         r_udf  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
         if (w_push && !w_pop)      r_used <= r_used + USED_W'(1);
         else if (!w_push && w_pop) r_used <= r_used - USED_W'(1);
         if (r_stg_vld && w_full && !w_pop) r_ovf <= 1'b1;
         if (out_rd && !w_not_empty)        r_udf <= 1'b1;
      end
   end

   assign in_rdy     = (DEPTH - int'(r_used)) > RDY_MARGIN;
   assign out_vld    = w_not_empty;
   assign out_sym    = w_not_empty ? r_mem_sym[r_rptr] : '0;
   assign out_cnt    = w_not_empty ? r_mem_cnt[r_rptr] : '0;
   assign out_seq_id = w_not_empty ? r_mem_seq[r_rptr] : '0;
   assign out_eob    = w_not_empty ? r_mem_eob[r_rptr] : '0;
   assign used_slots = r_used;
   assign overflow   = r_ovf;
   assign underflow  = r_udf;

endmodule

// File: tb/tb_cr_huf_comp_sym_coalesce.sv
// Scoreboard bench for cr_huf_comp_sym_coalesce: a list-based coalesce reference and an
// occupancy model predict FIFO contents; a monitor compares every popped head entry.
module tb_cr_huf_comp_sym_coalesce;
   localparam int LANES      = 4;
   localparam int SYM_W      = 10;
   localparam int DEPTH      = 16;
   localparam int RDY_MARGIN = 4;
   localparam int CNT_W      = $clog2(LANES + 1);
   localparam int USED_W     = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [LANES*SYM_W-1:0] sym;
      logic [LANES*CNT_W-1:0] cnt;
      logic [3:0]             seq;
      logic [1:0]             eob;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   merge_en;
   logic                   in_wr;
   logic [LANES-1:0]       in_vld;
   logic [LANES*SYM_W-1:0] in_sym;
   logic [3:0]             in_seq_id;
   logic [1:0]             in_eob;
   logic                   in_rdy;
   logic                   out_vld;
   logic [LANES*SYM_W-1:0] out_sym;
   logic [LANES*CNT_W-1:0] out_cnt;
   logic [3:0]             out_seq_id;
   logic [1:0]             out_eob;
   logic                   out_rd;
   logic [USED_W-1:0]      used_slots;
   logic                   overflow;
   logic                   underflow;

   cr_huf_comp_sym_coalesce #(
      .LANES(LANES), .SYM_W(SYM_W), .DEPTH(DEPTH), .RDY_MARGIN(RDY_MARGIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .merge_en(merge_en), .in_wr(in_wr), .in_vld(in_vld),
      .in_sym(in_sym), .in_seq_id(in_seq_id), .in_eob(in_eob), .in_rdy(in_rdy),
      .out_vld(out_vld), .out_sym(out_sym), .out_cnt(out_cnt), .out_seq_id(out_seq_id),
      .out_eob(out_eob), .out_rd(out_rd), .used_slots(used_slots),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int   errs   = 0;
   int   checks = 0;
   ent_t exp_q[$];
   int   m_cnt  = 0;
   logic m_ovf  = 1'b0;
   logic m_udf  = 1'b0;
   logic st_vld = 1'b0;
   ent_t st_ent;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: walk valid lanes, keep a list of distinct symbols seen and their tallies.
   function automatic ent_t ref_model(input logic [LANES-1:0] v, input logic [LANES*SYM_W-1:0] s,
                                      input logic m, input logic [3:0] q, input logic [1:0] e);
      int   syms[$];
      int   cnts[$];
      int   sy;
      int   hit;
      ent_t r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         if (v[i]) begin
            sy  = int'(s[i*SYM_W +: SYM_W]);
            hit = -1;
            if (m) foreach (syms[k]) if (hit < 0 && syms[k] == sy) hit = k;
            if (hit >= 0) cnts[hit] = cnts[hit] + 1;
            else begin
               syms.push_back(sy);
               cnts.push_back(1);
            end
         end
      end
      foreach (syms[k]) begin
         r.sym[k*SYM_W +: SYM_W] = SYM_W'(syms[k]);
         r.cnt[k*CNT_W +: CNT_W] = CNT_W'(cnts[k]);
      end
      r.seq = q;
      r.eob = e;
      return r;
   endfunction

   // Called right after a negedge with inputs already applied; checks status shortly before the
   // next posedge, then advances the model across that edge.
   task automatic tick();
      logic pop;
      logic acc;
      #4;
      chk("used_slots", 64'(used_slots), 64'(m_cnt));
      chk("in_rdy", 64'(in_rdy), 64'((DEPTH - m_cnt) > RDY_MARGIN));
      chk("out_vld", 64'(out_vld), 64'(m_cnt > 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_udf));
      if (rst_n) begin
         pop = out_rd && (m_cnt > 0);
         acc = st_vld && ((m_cnt < DEPTH) || pop);
         if (out_rd && m_cnt == 0) m_udf = 1'b1;
         if (st_vld && m_cnt == DEPTH && !pop) m_ovf = 1'b1;
         if (acc) exp_q.push_back(st_ent);
         m_cnt  = m_cnt + int'(acc) - int'(pop);
         st_vld = in_wr;
         if (in_wr) st_ent = ref_model(in_vld, in_sym, merge_en, in_seq_id, in_eob);
      end
      @(negedge clk);
   endtask

   // Monitor: every pop of a valid head is compared against the oldest expected entry.
   always begin
      ent_t got;
      ent_t exp;
      @(negedge clk);
      #4;
      if (rst_n && out_vld && out_rd) begin
         got    = {out_sym, out_cnt, out_seq_id, out_eob};
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errs = errs + 1;
            $display("FAIL head_entry: got %h but no entry expected", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errs = errs + 1;
               $display("FAIL head_entry: got %h expected %h", got, exp);
            end
         end
      end
   end

   function automatic logic [LANES*SYM_W-1:0] rand_syms();
      logic [LANES*SYM_W-1:0] s;
      for (int i = 0; i < LANES; i++)
         s[i*SYM_W +: SYM_W] = ($urandom_range(0, 3) == 0) ? SYM_W'($urandom) : SYM_W'($urandom_range(0, 3));
      return s;
   endfunction

   task automatic set_beat(input logic wr, input logic [LANES-1:0] v, input logic [LANES*SYM_W-1:0] s,
                           input logic [3:0] q, input logic [1:0] e);
      in_wr = wr; in_vld = v; in_sym = s; in_seq_id = q; in_eob = e;
   endtask

   task automatic drain();
      set_beat(1'b0, '0, '0, '0, '0);
      for (int n = 0; n < 4 * DEPTH && (m_cnt > 0 || st_vld); n++) begin
         out_rd = (m_cnt > 0);
         tick();
      end
      out_rd = 1'b0;
      chk("drain_empty", 64'(m_cnt), 64'd0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; st_vld = 1'b0;
   endtask

   initial begin
      logic [LANES*SYM_W-1:0] s;
      rst_n = 1'b0; merge_en = 1'b1; out_rd = 1'b0;
      set_beat(1'b0, '0, '0, '0, '0);
      #1;
      chk("rst_out_sym", 64'(out_sym), 64'd0);
      chk("rst_out_cnt", 64'(out_cnt), 64'd0);
      chk("rst_out_seq", 64'(out_seq_id), 64'd0);
      chk("rst_out_eob", 64'(out_eob), 64'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();

      // 4 lanes {5,5,7,5} merge to 5x3, 7x1.
      s = {SYM_W'(5), SYM_W'(7), SYM_W'(5), SYM_W'(5)};
      set_beat(1'b1, 4'b1111, s, 4'd1, 2'd0);
      tick();
      set_beat(1'b0, '0, '0, '0, '0);
      tick();
      chk("t1_vld", 64'(out_vld), 64'd1);
      chk("t1_sym", 64'(out_sym), 64'({SYM_W'(0), SYM_W'(0), SYM_W'(7), SYM_W'(5)}));
      chk("t1_cnt", 64'(out_cnt), 64'({CNT_W'(0), CNT_W'(0), CNT_W'(1), CNT_W'(3)}));
      out_rd = 1'b1;
      tick();
      out_rd = 1'b0;

      // Non-contiguous mask merged, then bypassed, then an empty beat.
      s = {SYM_W'(9), SYM_W'(33), SYM_W'(9), SYM_W'(44)};
      set_beat(1'b1, 4'b1010, s, 4'd2, 2'd1);
      tick();
      set_beat(1'b0, '0, '0, '0, '0);
      tick();
      merge_en = 1'b0;
      set_beat(1'b1, 4'b1010, s, 4'd4, 2'd1);
      tick();
      set_beat(1'b1, 4'b0000, rand_syms(), 4'd3, 2'd2);
      tick();
      merge_en = 1'b1;
      set_beat(1'b0, '0, '0, '0, '0);
      tick();
      drain();

      // Random traffic honouring in_rdy, reads only while out_vld.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) != 0 && in_rdy)
            set_beat(1'b1, LANES'($urandom), rand_syms(), 4'($urandom), 2'($urandom));
         else begin
            set_beat(1'b0, '0, '0, '0, '0);
            if ($urandom_range(0, 7) == 0) merge_en = ~merge_en;
         end
         out_rd = out_vld && ($urandom_range(0, 2) != 0);
         tick();
      end
      out_rd = 1'b0;
      drain();
      merge_en = 1'b1;

      // 17 forced writes with no reads: in_rdy falls at 12, 17th is dropped with overflow.
      for (int c = 0; c < DEPTH + 1; c++) begin
         set_beat(1'b1, LANES'($urandom), rand_syms(), 4'(c), 2'($urandom));
         tick();
      end
      set_beat(1'b0, '0, '0, '0, '0);
      tick();
      chk("full_used", 64'(used_slots), 64'(DEPTH));
      set_beat(1'b1, LANES'($urandom), rand_syms(), 4'($urandom), 2'($urandom));
      tick();
      // Push while full with simultaneous pop, across pointer wrap.
      out_rd = 1'b1;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         set_beat(1'b1, LANES'($urandom), rand_syms(), 4'($urandom), 2'($urandom));
         tick();
      end
      set_beat(1'b0, '0, '0, '0, '0);
      tick();
      drain();
      out_rd = 1'b1;
      tick();
      out_rd = 1'b0;
      tick();

      // Reset with entries buffered and a write in flight.
      for (int c = 0; c < 7; c++) begin
         set_beat(1'b1, LANES'($urandom), rand_syms(), 4'($urandom), 2'($urandom));
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_vld", 64'(out_vld), 64'd0);
      chk("rst_mid_used", 64'(used_slots), 64'd0);
      chk("rst_mid_ovf", 64'(overflow), 64'd0);
      chk("rst_mid_udf", 64'(underflow), 64'd0);
      model_reset();
      #2;
      tick();
      rst_n = 1'b1;
      set_beat(1'b0, '0, '0, '0, '0);
      for (int c = 0; c < 4; c++) tick();

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1);
   end
endmodule
